// File: rtl/ibex_hpm_ctrl.sv
// HPM controller: mcountinhibit, event selects, sticky overflow flags/enables; drives counter-body strobes.
// Latency: reads, strobes and increments are combinational; control writes and overflow flags update at the next edge.
// Backpressure: none; every CSR access completes in the cycle it is presented.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   csr_access_i/we_i/addr_i/wdata_i   CSR access port (single cycle)
//   csr_rdata_o, csr_illegal_o         combinational read data, unmapped-address flag
//   events_i                 raw per-cycle event pulses
//   cnt_inc_o, cnt_we_o, cnth_we_o, cnt_wdata_o   controls to the counter bodies
//   cnt_val_i                flattened 64-bit counter values, counter i at [64*i +: 64]
//   ovf_irq_o                level overflow interrupt, registered sources only
module ibex_hpm_ctrl #(
   parameter int unsigned NumCounters  = 4,
   parameter int unsigned NumEvents    = 8,
   parameter int unsigned CounterWidth = 40
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      csr_access_i,
   input  logic                      csr_we_i,
   input  logic [11:0]               csr_addr_i,
   input  logic [31:0]               csr_wdata_i,
   output logic [31:0]               csr_rdata_o,
   output logic                      csr_illegal_o,
   input  logic [NumEvents-1:0]      events_i,
   output logic [NumCounters-1:0]    cnt_inc_o,
   output logic [NumCounters-1:0]    cnt_we_o,
   output logic [NumCounters-1:0]    cnth_we_o,
   output logic [31:0]               cnt_wdata_o,
   input  logic [64*NumCounters-1:0] cnt_val_i,
   output logic                      ovf_irq_o
);

   localparam logic [11:0] AddrInhibit = 12'h320;
   localparam logic [11:0] AddrEvsel   = 12'h323;
   localparam logic [11:0] AddrCnt     = 12'hB03;
   localparam logic [11:0] AddrCnth    = 12'hB83;
   localparam logic [11:0] AddrOvf     = 12'h7C0;
   localparam logic [11:0] AddrOvfEn   = 12'h7C1;

   logic [NumCounters-1:0]                inhibit_q, inhibit_d;
   logic [NumCounters-1:0][NumEvents-1:0] evsel_q, evsel_d;
   logic [NumCounters-1:0]                ovf_q, ovf_d;
   logic [NumCounters-1:0]                ovf_en_q, ovf_en_d;

   logic                   mapped, csr_wr;
   logic                   sel_inh, sel_ovf, sel_ovfen;
   logic [NumCounters-1:0] sel_evsel, sel_cnt, sel_cnth;
   logic [NumCounters-1:0] wrap;
   logic [31:0]            rdata;

   // Address decode and read mux. At most one select is ever set for a given address.
   always_comb begin
      mapped    = 1'b0;
      sel_inh   = 1'b0;
      sel_ovf   = 1'b0;
      sel_ovfen = 1'b0;
      sel_evsel = '0;
      sel_cnt   = '0;
      sel_cnth  = '0;
      rdata     = '0;
      if (csr_addr_i == AddrInhibit) begin
         mapped                   = 1'b1;
         sel_inh                  = 1'b1;
         rdata[3 +: NumCounters]  = inhibit_q;
      end
      if (csr_addr_i == AddrOvf) begin
         mapped                      = 1'b1;
         sel_ovf                     = 1'b1;
         rdata[NumCounters-1:0]      = ovf_q;
      end
      if (csr_addr_i == AddrOvfEn) begin
         mapped                      = 1'b1;
         sel_ovfen                   = 1'b1;
         rdata[NumCounters-1:0]      = ovf_en_q;
      end
      for (int i = 0; i < NumCounters; i++) begin
         if (csr_addr_i == AddrEvsel + 12'(i)) begin
            mapped                 = 1'b1;
            sel_evsel[i]           = 1'b1;
            rdata[NumEvents-1:0]   = evsel_q[i];
         end
         if (csr_addr_i == AddrCnt + 12'(i)) begin
            mapped     = 1'b1;
            sel_cnt[i] = 1'b1;
            rdata      = cnt_val_i[64*i +: 32];
         end
         if (csr_addr_i == AddrCnth + 12'(i)) begin
            mapped      = 1'b1;
            sel_cnth[i] = 1'b1;
            rdata       = cnt_val_i[64*i+32 +: 32];
         end
      end
   end

   assign csr_wr        = csr_access_i & csr_we_i & mapped;
   assign csr_illegal_o = csr_access_i & ~mapped;
   assign csr_rdata_o   = rdata;
   assign cnt_wdata_o   = csr_wdata_i;
   assign cnt_we_o      = sel_cnt  & {NumCounters{csr_wr}};
   assign cnth_we_o     = sel_cnth & {NumCounters{csr_wr}};

   // A CSR write to a counter suppresses that counter's increment in the same cycle;
   // any number of matching events contributes a single increment.
   always_comb begin
      cnt_inc_o = '0;
      wrap      = '0;
      for (int i = 0; i < NumCounters; i++) begin
         cnt_inc_o[i] = (|(events_i & evsel_q[i])) & ~inhibit_q[i] & ~cnt_we_o[i] & ~cnth_we_o[i];
         wrap[i]      = cnt_inc_o[i] &
                        (cnt_val_i[64*i +: CounterWidth] == {CounterWidth{1'b1}});
      end
   end

   // Next-state for control registers. Overflow set is applied after the W1C clear so a
   // wrap in the same cycle as a clear leaves the flag set.
   always_comb begin
      inhibit_d = inhibit_q;
      evsel_d   = evsel_q;
      ovf_en_d  = ovf_en_q;
      ovf_d     = ovf_q;
      if (csr_wr && sel_inh) begin
         inhibit_d = csr_wdata_i[3 +: NumCounters];
      end
      if (csr_wr && sel_ovfen) begin
         ovf_en_d = csr_wdata_i[NumCounters-1:0];
      end
      for (int i = 0; i < NumCounters; i++) begin
         if (csr_wr && sel_evsel[i]) begin
            evsel_d[i] = csr_wdata_i[NumEvents-1:0];
         end
      end
      if (csr_wr && sel_ovf) begin
         ovf_d = ovf_q & ~csr_wdata_i[NumCounters-1:0];
      end
      ovf_d = ovf_d | wrap;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inhibit_q <= '0;
         evsel_q   <= '0;
         ovf_q     <= '0;
         ovf_en_q  <= '0;
      end else begin
         inhibit_q <= inhibit_d;
         evsel_q   <= evsel_d;
         ovf_q     <= ovf_d;
         ovf_en_q  <= ovf_en_d;
      end
   end

   assign ovf_irq_o = |(ovf_q & ovf_en_q);

endmodule
